// File: rtl/dram_responder_model_pkg.sv
// Shared types for the DRAM responder model: memory request/response beats,
// the responder FSM states and the memory word width.
package dram_responder_model_pkg;

    localparam int unsigned MEM_WORD_BITS = 512;

    typedef struct packed {
        logic                     valid;
        logic                     isWrite;
        logic [63:0]              addr;
        logic [MEM_WORD_BITS-1:0] data;
    } MemReq;

    typedef struct packed {
        logic                     valid;
        logic [MEM_WORD_BITS-1:0] data;
    } MemResp;

    typedef enum logic {
        INIT,
        RUN
    } ResponderState;

endpackage

// File: rtl/dram_responder_model_if.sv
// Request/response bus between a memory requester (master) and the
// responder model (slave).
interface dram_responder_model_if;
    import dram_responder_model_pkg::*;

    MemReq  mem_req;
    logic   mem_req_grant;
    MemResp mem_resp;
    logic   mem_resp_grant;

    modport master (
        output mem_req,
        output mem_resp_grant,
        input  mem_req_grant,
        input  mem_resp
    );

    modport slave (
        input  mem_req,
        input  mem_resp_grant,
        output mem_req_grant,
        output mem_resp
    );

endinterface

// File: rtl/dram_responder_model_fifo.sv
// Show-ahead FIFO with occupancy count; a push into a full FIFO is dropped.
module FIFO #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic                 empty,
    output logic [WIDTH-1:0]     head,
    output logic [LOG_DEPTH:0]   count
);

    logic [WIDTH-1:0]     store [2**LOG_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && !count[LOG_DEPTH];
    assign pop_ok  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dram_responder_model_rd_pipe.sv
// Fixed-latency valid/data shift pipeline for read data, reporting how many
// reads are currently travelling through it.
module dram_responder_rd_pipe
    import dram_responder_model_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = MEM_WORD_BITS,
    parameter int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] in_flight
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int unsigned i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
    end

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) in_flight = in_flight + CNT_W'(valid_q[i]);
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/dram_responder_model.sv
// On-chip memory responder: zero-fills its array, then serves in-order reads
// and writes. Define DRAM_RESPONDER_STATS_EN to build the statistics counters.
module dram_responder_model
    import dram_responder_model_pkg::*;
#(
    parameter int unsigned LOG_WORDS      = 10,
    parameter int unsigned ADDR_LSB       = 4,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned LOG_RESP_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dram_responder_model_if.slave  bus,
    output logic                   init_done,
    output logic [31:0]            stat_reads,
    output logic [31:0]            stat_writes,
    output logic [31:0]            stat_stalls
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    ResponderState             state_q, state_d;
    logic [LOG_WORDS-1:0]      init_idx_q;
    logic [MEM_WORD_BITS-1:0]  mem_array [2**LOG_WORDS];
    logic [LOG_WORDS-1:0]      req_idx;
    logic                      wr_grant, rd_grant, credit_ok;
    logic                      mem_we;
    logic [LOG_WORDS-1:0]      mem_wa;
    logic [MEM_WORD_BITS-1:0]  mem_wd;
    logic [CNT_W-1:0]          in_flight;
    logic                      pipe_valid;
    logic [MEM_WORD_BITS-1:0]  pipe_data;
    logic                      fifo_empty;
    logic [MEM_WORD_BITS-1:0]  fifo_head;
    logic [LOG_RESP_DEPTH:0]   fifo_count;
    logic                      addr_unused;

    assign req_idx     = bus.mem_req.addr[ADDR_LSB +: LOG_WORDS];
    assign addr_unused = ^bus.mem_req.addr;

    // Reads already in the pipe hold a FIFO slot, so the FIFO can never overflow.
    assign credit_ok = (32'(in_flight) + 32'(fifo_count)) < (32'd1 << LOG_RESP_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_idx_q <= init_idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = init_idx_q;
        mem_wd   = '0;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                if (init_idx_q == '1) state_d = RUN;
            end
            RUN: begin
                wr_grant = bus.mem_req.valid && bus.mem_req.isWrite;
                rd_grant = bus.mem_req.valid && !bus.mem_req.isWrite && credit_ok;
                mem_we   = wr_grant;
                mem_wa   = req_idx;
                mem_wd   = bus.mem_req.data;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_array[mem_wa] <= mem_wd;
    end

    assign bus.mem_req_grant = wr_grant || rd_grant;
    assign init_done         = (state_q == RUN);

    dram_responder_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (MEM_WORD_BITS)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_grant),
        .in_data   (mem_array[req_idx]),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .in_flight (in_flight)
    );

    FIFO #(
        .WIDTH     (MEM_WORD_BITS),
        .LOG_DEPTH (LOG_RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pipe_valid),
        .push_data (pipe_data),
        .pop       (bus.mem_resp_grant),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        bus.mem_resp.valid = !fifo_empty;
        bus.mem_resp.data  = fifo_empty ? '0 : fifo_head;
    end

`ifdef DRAM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else if (state_q == RUN) begin
            if (rd_grant) stat_reads  <= stat_reads + 1'b1;
            if (wr_grant) stat_writes <= stat_writes + 1'b1;
            if (bus.mem_req.valid && !bus.mem_req_grant) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_dram_responder_model.sv
// Directed bench for dram_responder_model; stat expectations follow
// DRAM_RESPONDER_STATS_EN (counters read zero when it is undefined).
module tb_dram_responder_model;
    import dram_responder_model_pkg::*;

`ifdef DRAM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_done;
    logic [31:0] stat_reads, stat_writes, stat_stalls;
    int          n_asserts = 0;
    int          n_fail = 0;
    int          bad;

    dram_responder_model_if bus ();

    dram_responder_model #(
        .LOG_WORDS      (10),
        .ADDR_LSB       (4),
        .READ_LATENCY   (2),
        .LOG_RESP_DEPTH (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .init_done   (init_done),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [511:0] d);
        bus.mem_req.valid   = 1'b1;
        bus.mem_req.isWrite = 1'b1;
        bus.mem_req.addr    = a;
        bus.mem_req.data    = d;
        #1 check("write_grant", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a);
        bus.mem_req.valid   = 1'b1;
        bus.mem_req.isWrite = 1'b0;
        bus.mem_req.addr    = a;
        #1 check("read_grant", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it and pops it.
    task automatic expect_resp(input string tag, input logic [511:0] exp);
        for (int i = 0; i < 20 && !bus.mem_resp.valid; i++) @(negedge clk);
        check({tag, "_valid"}, 512'(bus.mem_resp.valid), 512'(1));
        check({tag, "_data"}, bus.mem_resp.data, exp);
        bus.mem_resp_grant = 1'b1;
        @(negedge clk);
        bus.mem_resp_grant = 1'b0;
    endtask

    initial begin
        reset_n             = 1'b0;
        bus.mem_req         = '0;
        bus.mem_resp_grant  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 512'(bus.mem_req_grant), 512'(0));
        check("rst_resp", 512'(bus.mem_resp), 512'(0));
        check("rst_init_done", 512'(init_done), 512'(0));
        check("rst_stats", 512'({stat_reads, stat_writes, stat_stalls}), 512'(0));

        // Init: a read to addr 0 is held the whole time and must wait 1024 cycles.
        bus.mem_req.valid = 1'b1;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (bus.mem_req_grant !== 1'b0 || init_done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("init_quiet_cycles", 512'(bad), 512'(0));
        check("init_done_1024", 512'(init_done), 512'(1));
        check("init_read_grant", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
        expect_resp("init_zero", '0);

        // Write/readback with exact response timing.
        do_write(64'h00, {16{32'hA5A5A5A5}});
        do_write(64'h10, {16{32'h12345678}});
        do_write(64'h20, '1);
        bus.mem_resp_grant  = 1'b1;
        bus.mem_req.valid   = 1'b1;
        bus.mem_req.isWrite = 1'b0;
        bus.mem_req.addr    = 64'h00;
        #1 check("rb_grant0", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.addr = 64'h10;
        #1 check("rb_grant1", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.addr = 64'h20;
        #1 check("rb_grant2", 512'(bus.mem_req_grant), 512'(1));
        check("rb_not_yet", 512'(bus.mem_resp.valid), 512'(0));
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
        check("rb_v0", 512'(bus.mem_resp.valid), 512'(1));
        check("rb_d0", bus.mem_resp.data, {16{32'hA5A5A5A5}});
        @(negedge clk);
        check("rb_d1", bus.mem_resp.data, {16{32'h12345678}});
        @(negedge clk);
        check("rb_d2", bus.mem_resp.data, '1);
        @(negedge clk);
        check("rb_empty", 512'(bus.mem_resp.valid), 512'(0));
        bus.mem_resp_grant = 1'b0;

        // Backpressure: only 8 of 12 reads fit while nothing is consumed.
        for (int i = 0; i < 12; i++) do_write(64'(i * 16), 512'(i + 256));
        for (int i = 0; i < 12; i++) begin
            bus.mem_req.valid   = 1'b1;
            bus.mem_req.isWrite = 1'b0;
            bus.mem_req.addr    = 64'((i < 8 ? i : 8) * 16);
            #1 check($sformatf("bp_grant%0d", i), 512'(bus.mem_req_grant), 512'(i < 8));
            @(negedge clk);
        end
        bus.mem_req.valid = 1'b0;
        check("bp_stalls", 512'(stat_stalls), 512'(exp_stat(4)));
        for (int j = 0; j < 8; j++) expect_resp($sformatf("bp_resp%0d", j), 512'(j + 256));
        for (int j = 8; j < 12; j++) do_read(64'(j * 16));
        for (int j = 8; j < 12; j++) expect_resp($sformatf("bp_resp%0d", j), 512'(j + 256));

        // Address wrap and ignored address bits.
        do_write(64'h4000, 512'hBEEF);
        do_read(64'h0);
        expect_resp("wrap", 512'hBEEF);
        do_read(64'hFFFF_0000_0000_001F);
        expect_resp("addr_ignore", 512'h101);

        // Read the cycle after a write to the same word.
        do_write(64'h30, 512'h77);
        do_read(64'h30);
        expect_resp("raw", 512'h77);

        check("stat_reads", 512'(stat_reads), 512'(exp_stat(19)));
        check("stat_writes", 512'(stat_writes), 512'(exp_stat(17)));
        check("stat_stalls", 512'(stat_stalls), 512'(exp_stat(4)));

        // Mid-operation reset with reads outstanding.
        do_read(64'h00);
        do_read(64'h10);
        do_read(64'h20);
        check("mid_pending", 512'(bus.mem_resp.valid), 512'(1));
        reset_n = 1'b0;
        #1 check("mid_resp_drop", 512'(bus.mem_resp), 512'(0));
        check("mid_init_done", 512'(init_done), 512'(0));
        check("mid_stats", 512'({stat_reads, stat_writes, stat_stalls}), 512'(0));
        repeat (2) @(negedge clk);
        bus.mem_req.valid   = 1'b1;
        bus.mem_req.isWrite = 1'b0;
        bus.mem_req.addr    = 64'h10;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (bus.mem_req_grant !== 1'b0 || init_done !== 1'b0 || bus.mem_resp.valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("reinit_quiet_cycles", 512'(bad), 512'(0));
        check("reinit_done", 512'(init_done), 512'(1));
        check("reinit_grant", 512'(bus.mem_req_grant), 512'(1));
        @(negedge clk);
        bus.mem_req.valid = 1'b0;
        expect_resp("reinit_zero", '0);
        check("reinit_reads", 512'(stat_reads), 512'(exp_stat(1)));
        check("reinit_stalls", 512'(stat_stalls), 512'(exp_stat(0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
